// File: rtl/spi_bridge_wide.sv
// spi_bridge_wide: SPI slave bridging an asynchronous SPI bus into the clk domain, WORD_W-bit words.
// Define SPI_BRIDGE_WIDE_WORD_CNT_EN to add the per-frame word_cnt output.
module spi_bridge_wide #(
    parameter int WORD_W    = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              word_sync,
    output logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] data_out,
    output logic              frame_abort
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
    ,
    output logic [7:0]        word_cnt
`endif
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic P_IDLE = 1'(CPOL);
    logic [1:0] r_sclk_s, r_cs_s, r_mosi_s, r_rdy;
    logic r_sclk_d, r_cs_d, r_armed;
    logic [WORD_W-1:0] r_rx_sr, r_tx_sr;
    logic [CNT_W-1:0] r_bit_cnt;
    logic w_sclk, w_cs, w_mosi, w_lead, w_trail, w_sample, w_shift;
    logic w_active, w_cs_fall, w_cs_rise, w_last, w_tx_load;
    logic [WORD_W-1:0] w_rx_next, w_tx_next;
    assign w_sclk    = r_sclk_s[1];
    assign w_cs      = r_cs_s[1];
    assign w_mosi    = r_mosi_s[1];
    assign w_lead    = (r_sclk_d == P_IDLE) && (w_sclk != P_IDLE);
    assign w_trail   = (r_sclk_d != P_IDLE) && (w_sclk == P_IDLE);
    assign w_sample  = (CPHA == 0) ? w_lead : w_trail;
    assign w_shift   = (CPHA == 0) ? w_trail : w_lead;
    // r_armed blocks a frame still in progress across rst from restarting until cs_n has been seen high
    assign w_active  = r_armed & ~w_cs;
    assign w_cs_fall = r_armed & r_cs_d & ~w_cs;
    assign w_cs_rise = r_armed & ~r_cs_d & w_cs;
    assign w_last    = r_bit_cnt == CNT_W'(WORD_W - 1);
    assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_sr[WORD_W-2:0], w_mosi} : {w_mosi, r_rx_sr[WORD_W-1:1]};
    assign w_tx_next = (MSB_FIRST != 0) ? {r_tx_sr[WORD_W-2:0], 1'b0} : {1'b0, r_tx_sr[WORD_W-1:1]};
    // A shift edge seen at bit_cnt 0 is the first one of a new word
    assign w_tx_load = (w_active & w_shift & (r_bit_cnt == '0)) | ((CPHA == 0) & w_cs_fall);
    assign miso      = ~w_cs & ((MSB_FIRST != 0) ? r_tx_sr[WORD_W-1] : r_tx_sr[0]);
    assign miso_oe   = ~w_cs;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s    <= {2{P_IDLE}};
            r_cs_s      <= 2'b11;
            r_mosi_s    <= 2'b00;
            r_sclk_d    <= P_IDLE;
            r_cs_d      <= 1'b1;
            r_rdy       <= 2'b00;
            r_armed     <= 1'b0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_bit_cnt   <= '0;
            data_in     <= '0;
            word_sync   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            r_sclk_s    <= {r_sclk_s[0], sclk};
            r_cs_s      <= {r_cs_s[0], cs_n};
            r_mosi_s    <= {r_mosi_s[0], mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_rdy       <= {r_rdy[0], 1'b1};
            word_sync   <= 1'b0;
            frame_abort <= 1'b0;
            if (r_rdy[1] & w_cs)
                r_armed <= 1'b1;
            if (w_cs_rise) begin
                r_rx_sr     <= '0;
                r_bit_cnt   <= '0;
                frame_abort <= r_bit_cnt != '0;
            end else if (w_active & w_sample) begin
                r_rx_sr   <= w_rx_next;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
                if (w_last) begin
                    data_in   <= w_rx_next;
                    word_sync <= 1'b1;
                end
            end
            if (w_tx_load)
                r_tx_sr <= data_out;
            else if (w_active & w_shift)
                r_tx_sr <= w_tx_next;
        end
    end
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || w_cs_fall)
            word_cnt <= '0;
        else if (word_sync && word_cnt != 8'hFF)
            word_cnt <= word_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_spi_bridge_wide.sv
// tb_spi_bridge_wide: three bridge configurations driven by an SPI master model, scoreboarded on word_sync.
module tb_spi_bridge_wide;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] sclk_a, cs_a, mosi_a, miso_w, oe_w, ws_w, fa_w;
    logic [7:0] di0, di2, do0, do2;
    logic [15:0] di1, do1;
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
    logic [7:0] wc0;
`endif
    int n_vec = 0;
    int n_err = 0;
    int ws_cnt[3] = '{0, 0, 0};
    int fa_cnt[3] = '{0, 0, 0};
    int cw[3] = '{8, 16, 8};
    int cp[3] = '{0, 1, 0};
    int ch[3] = '{0, 1, 0};
    int cm[3] = '{1, 1, 0};
    logic [31:0] q0[$], q1[$], q2[$];
    logic [31:0] m;

    always #5 clk = ~clk;

    spi_bridge_wide #(.WORD_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk_a[0]), .cs_n(cs_a[0]), .mosi(mosi_a[0]),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .word_sync(ws_w[0]), .data_in(di0),
        .data_out(do0), .frame_abort(fa_w[0])
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
        , .word_cnt(wc0)
`endif
    );
    spi_bridge_wide #(.WORD_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk_a[1]), .cs_n(cs_a[1]), .mosi(mosi_a[1]),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .word_sync(ws_w[1]), .data_in(di1),
        .data_out(do1), .frame_abort(fa_w[1])
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
        , .word_cnt()
`endif
    );
    spi_bridge_wide #(.WORD_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .sclk(sclk_a[2]), .cs_n(cs_a[2]), .mosi(mosi_a[2]),
        .miso(miso_w[2]), .miso_oe(oe_w[2]), .word_sync(ws_w[2]), .data_in(di2),
        .data_out(do2), .frame_abort(fa_w[2])
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
        , .word_cnt()
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fa_w[i]) fa_cnt[i]++;
            if (ws_w[i]) ws_cnt[i]++;
        end
        if (ws_w[0]) begin
            if (q0.size() == 0) check("ws0_unexpected", 1, 0);
            else check("ws0_data", {24'h0, di0}, q0.pop_front());
        end
        if (ws_w[1]) begin
            if (q1.size() == 0) check("ws1_unexpected", 1, 0);
            else check("ws1_data", {16'h0, di1}, q1.pop_front());
        end
        if (ws_w[2]) begin
            if (q2.size() == 0) check("ws2_unexpected", 1, 0);
            else check("ws2_data", {24'h0, di2}, q2.pop_front());
        end
    end

    task automatic cs_lo(input int i);
        cs_a[i] = 1'b0;
        #80;
    endtask

    task automatic cs_hi(input int i);
        #40;
        cs_a[i] = 1'b1;
        #120;
    endtask

    task automatic xfer(input int i, input logic [31:0] w, input int nb, output logic [31:0] mo);
        int p;
        mo = '0;
        for (int b = 0; b < nb; b++) begin
            p = (cm[i] != 0) ? cw[i] - 1 - b : b;
            if (ch[i] == 0) begin
                mosi_a[i] = w[p];
                #40;
                mo[p] = miso_w[i];
                sclk_a[i] = ~1'(cp[i]);
                #40;
                sclk_a[i] = 1'(cp[i]);
            end else begin
                sclk_a[i] = ~1'(cp[i]);
                mosi_a[i] = w[p];
                #40;
                mo[p] = miso_w[i];
                sclk_a[i] = 1'(cp[i]);
                #40;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        sclk_a = 3'b010;
        cs_a   = 3'b111;
        mosi_a = 3'b000;
        do0 = 8'h3C;
        do1 = 16'hC0DE;
        do2 = 8'h96;
        repeat (3) @(negedge clk);
        check("rst_data_in0", {24'h0, di0}, 0);
        check("rst_data_in1", {16'h0, di1}, 0);
        check("rst_word_sync", {29'h0, ws_w}, 0);
        check("rst_abort", {29'h0, fa_w}, 0);
        check("rst_miso", {29'h0, miso_w}, 0);
        check("rst_miso_oe", {29'h0, oe_w}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        q0.push_back(32'hA5);
        cs_lo(0);
        check("t27_miso_oe", {31'h0, oe_w[0]}, 1);
        xfer(0, 32'hA5, 8, m);
        check("t27_miso", m, 32'h3C);
        cs_hi(0);
        check("t27_ws_cnt", ws_cnt[0], 1);
        check("t27_data_in", {24'h0, di0}, 32'hA5);
        check("t27_miso_oe_idle", {31'h0, oe_w[0]}, 0);
        q1.push_back(32'h1234);
        q1.push_back(32'hBEEF);
        cs_lo(1);
        xfer(1, 32'h1234, 16, m);
        check("t28_miso_w0", m, 32'hC0DE);
        xfer(1, 32'hBEEF, 16, m);
        check("t28_miso_w1", m, 32'hC0DE);
        cs_hi(1);
        check("t28_ws_cnt", ws_cnt[1], 2);
        check("t28_data_in", {16'h0, di1}, 32'hBEEF);
        check("t28_abort", fa_cnt[1], 0);
        q2.push_back(32'h01);
        cs_lo(2);
        xfer(2, 32'h01, 8, m);
        check("t29_miso", m, 32'h96);
        cs_hi(2);
        check("t29_data_in", {24'h0, di2}, 32'h01);
        cs_lo(0);
        xfer(0, 32'hC3, 5, m);
        cs_hi(0);
        check("t30_abort_cnt", fa_cnt[0], 1);
        check("t30_ws_cnt", ws_cnt[0], 1);
        check("t30_data_in", {24'h0, di0}, 32'hA5);
        q0.push_back(32'h5A);
        cs_lo(0);
        xfer(0, 32'h5A, 8, m);
        cs_hi(0);
        check("t30_next_data_in", {24'h0, di0}, 32'h5A);
        check("t30_next_abort", fa_cnt[0], 1);
        cs_lo(0);
        xfer(0, 32'hFF, 3, m);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t31_data_in", {24'h0, di0}, 0);
        check("t31_word_sync", {31'h0, ws_w[0]}, 0);
        check("t31_abort", {31'h0, fa_w[0]}, 0);
        check("t31_miso", {31'h0, miso_w[0]}, 0);
        check("t31_miso_oe", {31'h0, oe_w[0]}, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        cs_hi(0);
        check("t31_no_abort", fa_cnt[0], 1);
        check("t31_ws_cnt", ws_cnt[0], 2);
        q0.push_back(32'hFF);
        cs_lo(0);
        xfer(0, 32'hFF, 8, m);
        cs_hi(0);
        check("t31_data_in_ff", {24'h0, di0}, 32'hFF);
`ifdef SPI_BRIDGE_WIDE_WORD_CNT_EN
        q0.push_back(32'h11);
        q0.push_back(32'h22);
        q0.push_back(32'h33);
        cs_lo(0);
        xfer(0, 32'h11, 8, m);
        xfer(0, 32'h22, 8, m);
        xfer(0, 32'h33, 8, m);
        cs_hi(0);
        check("t32_word_cnt", {24'h0, wc0}, 3);
        cs_lo(0);
        check("t32_word_cnt_clr", {24'h0, wc0}, 0);
        cs_hi(0);
`endif
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_bridge_wide.md
SPI_BRIDGE_WIDE -- requirements
Module: spi_bridge_wide

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the SPI word length in bits; legal range 4..32.
REQ-002 Parameter CPOL, default 0, SHALL set the idle SCLK level.
REQ-003 Parameter CPHA, default 0, SHALL select the sample edge: 0 = leading edge, 1 = trailing edge.
REQ-004 Parameter MSB_FIRST, default 1, SHALL select bit order: 1 = MSB first, 0 = LSB first.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  peripheral clock
- rst  in  1  synchronous active-high reset
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out
- miso_oe  out  1  high while the frame is active
- word_sync  out  1  one-cycle pulse when a word is received
- data_in  out  WORD_W  last received word
- data_out  in  WORD_W  word to transmit, sampled at each word load
- frame_abort  out  1  one-cycle pulse when cs_n rises mid-word
REQ-006 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-007 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer on clk; all logic SHALL use only the synchronized versions.
REQ-008 clk SHALL be at least 4x the sclk frequency; no behaviour is defined below this ratio.
REQ-009 Leading edge SHALL mean synchronized sclk leaving CPOL; trailing edge SHALL mean it returning to CPOL; each edge SHALL be detected for exactly one clk cycle.
REQ-010 SCLK edges SHALL be ignored while synchronized cs_n is high; bit counter and shift registers SHALL hold.
REQ-011 Sample edge: mosi_sync SHALL shift into rx_sr in the order set by MSB_FIRST, and bit_cnt (range 0..WORD_W-1) SHALL increment, wrapping to 0.
REQ-012 On the sample edge with bit_cnt = WORD_W-1, data_in SHALL be loaded with the completed word and word_sync SHALL pulse high in the next clk cycle.
REQ-013 data_in SHALL hold its value until the next completed word.
REQ-014 Words SHALL be received back-to-back within one frame, without limit.
REQ-015 CPHA=0 transmit: tx_sr SHALL load data_out on the synchronized cs_n falling edge, and on the first shift edge after each completed word; on all other shift (trailing) edges it SHALL shift.
REQ-016 CPHA=1 transmit: on a leading edge with bit_cnt = 0, tx_sr SHALL load data_out; on other leading edges it SHALL shift.
REQ-017 miso SHALL equal the tx_sr bit selected by MSB_FIRST while cs_n_sync is low, and 0 otherwise.
REQ-018 miso_oe SHALL equal the inverse of cs_n_sync.
REQ-019 cs_n_sync rising with bit_cnt != 0: frame_abort SHALL pulse for one cycle, the partial word SHALL be discarded, data_in SHALL be unchanged, word_sync SHALL stay low, and bit_cnt SHALL clear to 0.
REQ-020 cs_n_sync rising with bit_cnt = 0: no pulse SHALL be generated.
REQ-021 A cs_n_sync rise in the same cycle as a detected sample edge SHALL take priority; that edge SHALL be ignored.

Reset
REQ-022 On rst, the sclk synchronizer stages SHALL reset to CPOL, the cs_n stages to 1, and the mosi stages to 0.
REQ-023 On rst: rx_sr, tx_sr, bit_cnt and data_in SHALL be 0; word_sync, frame_abort, miso and miso_oe SHALL be 0.
REQ-024 rst asserted mid-frame SHALL discard the partial word with no frame_abort; the block SHALL restart only after a new cs_n falling edge.

Configuration
REQ-025 With macro SPI_BRIDGE_WIDE_WORD_CNT_EN defined, an output word_cnt [7:0] SHALL exist.
- It SHALL increment on each word_sync, saturating at 255.
- It SHALL clear on the cs_n_sync falling edge and on rst.
REQ-026 Without SPI_BRIDGE_WIDE_WORD_CNT_EN, the word_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 WORD_W=8, CPOL=0, CPHA=0, MSB_FIRST=1; send mosi 0xA5 with data_out=0x3C -> one word_sync, data_in=0xA5, miso bits 0,0,1,1,1,1,0,0.
REQ-028 WORD_W=16, CPOL=1, CPHA=1; two back-to-back words 0x1234, 0xBEEF in one frame -> two word_sync pulses, data_in 0x1234 then 0xBEEF.
REQ-029 WORD_W=8, MSB_FIRST=0; send 0x01 LSB-first -> data_in=0x01.
REQ-030 cs_n raised after 5 of 8 bits -> frame_abort pulses once, no word_sync, data_in unchanged; the next full frame with 0x5A -> data_in=0x5A.
REQ-031 rst pulsed after 3 bits, then a full frame 0xFF -> all outputs 0 after rst, no frame_abort, data_in=0xFF after the frame.
REQ-032 With SPI_BRIDGE_WIDE_WORD_CNT_EN defined, 3 words in one frame -> word_cnt=3; a new frame -> word_cnt clears to 0.
